// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package inst_fetch_pkg;

    localparam int unsigned InstAddrBusW = 32;
    localparam int unsigned InstBusW     = 32;

    localparam logic [InstBusW-1:0] ZeroWord = '0;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    // Prefetch queue depth; only 2 is exercised.
    localparam int unsigned FetchQDepth = 2;

    // Fetch state machine encodings.
    typedef enum logic [1:0] {
        FetchBoot = 2'b00,
        FetchRun  = 2'b01,
        FetchFull = 2'b10
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [InstAddrBusW-1:0] word_align(input logic [InstAddrBusW-1:0] addr);
        return addr & ~{{(InstAddrBusW - 2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {pc, inst} pairs feeding the IF/ID stage.
// Flush and reset both empty the queue; storage contents are don't-care when empty.
module fetch_queue
    import inst_fetch_pkg::*;
#(
    parameter int unsigned Depth = FetchQDepth,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [InstAddrBusW-1:0] push_pc_i,
    input  logic [InstBusW-1:0]     push_inst_i,
    input  logic                    pop_i,
    output logic [CntW-1:0]         count_o,
    output logic [CntW-1:0]         count_next_o,
    output logic [InstAddrBusW-1:0] head_pc_o,
    output logic [InstBusW-1:0]     head_inst_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [InstAddrBusW-1:0] mem_pc_q   [Depth];
    logic [InstBusW-1:0]     mem_inst_q [Depth];

    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    // A push into a full queue is only accepted when a pop frees a slot.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);
    end

    // Pointer and occupancy next-state; flush overrides everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; no reset needed because empty entries are never presented.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && do_push) begin
            mem_pc_q[wr_ptr_q]   <= push_pc_i;
            mem_inst_q[wr_ptr_q] <= push_inst_i;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_pc_o    = mem_pc_q[rd_ptr_q];
    assign head_inst_o  = mem_inst_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front-end: owns the PC, drives the combinational ROM and
// presents the head of a small prefetch queue to IF/ID with a valid/stall handshake.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBusW-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned             QDEPTH   = FetchQDepth
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    branch_flag_i,
    input  logic [InstAddrBusW-1:0] branch_target_i,
    output logic                    rom_ce_o,
    output logic [InstAddrBusW-1:0] rom_addr_o,
    input  logic [InstBusW-1:0]     rom_inst_i,
    output logic                    id_valid_o,
    output logic [InstAddrBusW-1:0] id_pc_o,
    output logic [InstBusW-1:0]     id_inst_o
);

    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    fetch_state_e state_q, state_d;
    logic [InstAddrBusW-1:0] pc_q, pc_d;

    logic [CntW-1:0]         q_count;
    logic [CntW-1:0]         q_count_next;
    logic [InstAddrBusW-1:0] q_head_pc;
    logic [InstBusW-1:0]     q_head_inst;

    logic pop;
    logic fetch;
    logic push;

    fetch_queue #(
        .Depth (QDEPTH)
    ) u_fetch_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (branch_flag_i),
        .push_i       (push),
        .push_pc_i    (pc_q),
        .push_inst_i  (rom_inst_i),
        .pop_i        (pop),
        .count_o      (q_count),
        .count_next_o (q_count_next),
        .head_pc_o    (q_head_pc),
        .head_inst_o  (q_head_inst)
    );

    // Issue logic: RUN always has room; FULL only issues when a pop frees a slot
    // this cycle, so a released stall resumes fetching without a bubble.
    always_comb begin
        pop   = id_valid_o && !stall_i;
        fetch = 1'b0;
        if (!rst) begin
            case (state_q)
                FetchRun:  fetch = 1'b1;
                FetchFull: fetch = pop;
                default:   fetch = 1'b0;
            endcase
        end
        // A redirect discards whatever the ROM returns this cycle.
        push = fetch && !branch_flag_i;
    end

    // Next state and next PC; branch beats stall and BOOT, reset beats branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (branch_flag_i) begin
            state_d = FetchRun;
            pc_d    = word_align(branch_target_i);
        end else begin
            case (state_q)
                FetchBoot: state_d = FetchRun;
                FetchRun, FetchFull: begin
                    state_d = (q_count_next == CntW'(QDEPTH)) ? FetchFull : FetchRun;
                end
                default: state_d = FetchBoot;
            endcase
            if (fetch) pc_d = pc_q + 32'd4;
        end
    end

    // State machine and PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FetchBoot;
            pc_q    <= word_align(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // ROM side: address always follows the PC, even with the chip disabled.
    assign rom_ce_o   = fetch ? ChipEnable : ChipDisable;
    assign rom_addr_o = rst ? word_align(RESET_PC) : word_align(pc_q);

    // IF/ID side: queue head, zeroed when nothing is valid.
    assign id_valid_o = (q_count != '0);
    assign id_pc_o    = id_valid_o ? q_head_pc : '0;
    assign id_inst_o  = id_valid_o ? q_head_inst : ZeroWord;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// stall/branch/reset traffic against a queue-based reference model.
module tb_inst_fetch;

    localparam logic [31:0] ResetPc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] m_pc_q[$];
    logic [31:0] m_inst_q[$];
    logic [31:0] m_fpc;
    bit          m_boot;
    bit          m_init = 0;

    // Values observed in the most recent stepped cycle.
    logic        obs_ce;
    logic        obs_valid;
    logic [31:0] obs_addr;
    logic [31:0] obs_pc;
    logic [31:0] obs_inst;

    always #5 clk = ~clk;

    // ROM contents: word at address 0 is 32'h00500093.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign rom_inst_i = rom_ce_o ? rom_word(rom_addr_o) : 32'h0;

    inst_fetch #(
        .RESET_PC (ResetPc),
        .QDEPTH   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce_o        (rom_ce_o),
        .rom_addr_o      (rom_addr_o),
        .rom_inst_i      (rom_inst_i),
        .id_valid_o      (id_valid_o),
        .id_pc_o         (id_pc_o),
        .id_inst_o       (id_inst_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model mid-cycle, then
    // advance the model at the rising edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic        e_valid;
        logic        e_ce;
        logic        pop;
        int          occ;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_addr;

        rst             = r;
        stall_i         = s;
        branch_flag_i   = b;
        branch_target_i = t;
        @(negedge clk);
        obs_ce    = rom_ce_o;
        obs_valid = id_valid_o;
        obs_addr  = rom_addr_o;
        obs_pc    = id_pc_o;
        obs_inst  = id_inst_o;

        e_valid = (m_pc_q.size() != 0);
        pop     = e_valid && !s;
        occ     = m_pc_q.size() - (pop ? 1 : 0);
        e_ce    = !r && !m_boot && (occ < 2);
        e_pc    = e_valid ? m_pc_q[0] : 32'h0;
        e_inst  = e_valid ? m_inst_q[0] : 32'h0;
        e_addr  = r ? ResetPc : m_fpc;

        if (m_init) begin
            check_eq("id_valid", {31'b0, obs_valid}, {31'b0, e_valid});
            check_eq("id_pc", obs_pc, e_pc);
            check_eq("id_inst", obs_inst, e_inst);
            check_eq("rom_ce", {31'b0, obs_ce}, {31'b0, e_ce});
            check_eq("rom_addr", obs_addr, e_addr);
        end

        @(posedge clk);
        if (r) begin
            m_pc_q.delete();
            m_inst_q.delete();
            m_fpc  = ResetPc;
            m_boot = 1;
            m_init = 1;
        end else if (b) begin
            m_pc_q.delete();
            m_inst_q.delete();
            m_fpc  = t & 32'hFFFF_FFFC;
            m_boot = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else begin
            if (pop) begin
                void'(m_pc_q.pop_front());
                void'(m_inst_q.pop_front());
            end
            if (e_ce) begin
                m_pc_q.push_back(m_fpc);
                m_inst_q.push_back(rom_word(m_fpc));
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        logic        r;
        logic        s;
        logic        b;
        logic [31:0] t;

        m_fpc  = ResetPc;
        m_boot = 1;

        // Reset, then release: BOOT, fetch, present.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("boot_ce", {31'b0, obs_ce}, 32'd0);
        step(0, 0, 0, 0);
        check_eq("first_fetch_ce", {31'b0, obs_ce}, 32'd1);
        check_eq("first_fetch_addr", obs_addr, 32'h0);
        step(0, 0, 0, 0);
        check_eq("first_valid", {31'b0, obs_valid}, 32'd1);
        check_eq("first_pc", obs_pc, 32'h0);
        check_eq("first_inst", obs_inst, 32'h0050_0093);

        // Free run: consecutive PCs with no gaps.
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0);
            check_eq("run_pc", obs_pc, 32'(4 * i));
        end

        // Mid-run reset returns outputs to reset values.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("rst_valid", {31'b0, obs_valid}, 32'd0);
        check_eq("rst_pc", obs_pc, 32'h0);
        check_eq("rst_inst", obs_inst, 32'h0);
        check_eq("rst_ce", {31'b0, obs_ce}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Stall four cycles with head at 8.
        step(0, 1, 0, 0);
        check_eq("stall_head", obs_pc, 32'h8);
        check_eq("stall_ce0", {31'b0, obs_ce}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            check_eq("stall_head", obs_pc, 32'h8);
            check_eq("stall_full_ce", {31'b0, obs_ce}, 32'd0);
        end
        step(0, 0, 0, 0);
        check_eq("release_pc", obs_pc, 32'h8);
        check_eq("release_ce", {31'b0, obs_ce}, 32'd1);
        step(0, 0, 0, 0);
        check_eq("release_pc", obs_pc, 32'hC);

        // Branch while head is 0x10; 0x14 must never appear.
        step(0, 0, 1, 32'h103);
        check_eq("branch_head", obs_pc, 32'h10);
        step(0, 0, 0, 0);
        check_eq("branch_bubble", {31'b0, obs_valid}, 32'd0);
        step(0, 0, 0, 0);
        check_eq("branch_target_pc", obs_pc, 32'h100);

        // Branch during a stall while FULL discards the stalled entries.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check_eq("full_ce", {31'b0, obs_ce}, 32'd0);
        step(0, 1, 1, 32'h200);
        step(0, 0, 0, 0);
        check_eq("full_branch_bubble", {31'b0, obs_valid}, 32'd0);
        step(0, 0, 0, 0);
        check_eq("full_branch_pc", obs_pc, 32'h200);

        // PC wrap.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check_eq("wrap_pc0", obs_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        check_eq("wrap_pc1", obs_pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 1);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else t = $urandom;
            step(r, s, b, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
